// File: rtl/apb_req_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// apb_req_arbiter : round-robin arbiter sharing one APB master port between
//                   two level-request clients (APB_ARB_ADDR_CHECK_EN adds an
//                   address window check on 0x1000_0000-0x1000_3FFF).
// Revision: 1.0
// ----------------------------------------------------------------------------
module apb_req_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] wdata0,
  input  logic [ADDR_W-1:0] wdata1,
  input  logic              write0,
  input  logic              write1,
  output logic              done0,
  output logic              done1,
  output logic [ADDR_W-1:0] rdata0,
  output logic [ADDR_W-1:0] rdata1,
  output logic              err0,
  output logic              err1,
  output logic              transfer,
  output logic [ADDR_W-1:0] m_addr,
  output logic [ADDR_W-1:0] m_wdata,
  output logic              m_write,
  input  logic              m_ready,
  input  logic [ADDR_W-1:0] m_rdata
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    SETUP  = 3'd2,
    ACCESS = 3'd3,
    DONE   = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              prio_q, prio_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] wdata_q, wdata_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] rdata0_q, rdata0_d;
  logic [ADDR_W-1:0] rdata1_q, rdata1_d;

  logic              sel;
  logic [ADDR_W-1:0] sel_addr;
  logic              addr_ok;

  // prio_q names the requester that wins when both are asking
  assign sel      = (req0 & req1) ? prio_q : req1;
  assign sel_addr = sel ? addr1 : addr0;

`ifdef APB_ARB_ADDR_CHECK_EN
  localparam logic [ADDR_W-1:0] WIN_LO = ADDR_W'(32'h1000_0000);
  localparam logic [ADDR_W-1:0] WIN_HI = ADDR_W'(32'h1000_3FFF);

  logic err0_q, err0_d;
  logic err1_q, err1_d;

  assign addr_ok = (sel_addr >= WIN_LO) && (sel_addr <= WIN_HI);
  assign err0    = err0_q;
  assign err1    = err1_q;
`else
  assign addr_ok = 1'b1;
  assign err0    = 1'b0;
  assign err1    = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    prio_d   = prio_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    write_d  = write_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
`ifdef APB_ARB_ADDR_CHECK_EN
    err0_d   = err0_q;
    err1_d   = err1_q;
`endif
    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          gnt_d   = sel;
          addr_d  = sel_addr;
          wdata_d = sel ? wdata1 : wdata0;
          write_d = sel ? write1 : write0;
          // A rejected address skips the bus entirely and completes next cycle
          state_d = addr_ok ? ISSUE : DONE;
`ifdef APB_ARB_ADDR_CHECK_EN
          if (sel) err1_d = ~addr_ok;
          else     err0_d = ~addr_ok;
`endif
        end
      end
      ISSUE:  state_d = SETUP;
      SETUP:  state_d = ACCESS;
      ACCESS: begin
        if (m_ready) begin
          if (!write_q) begin
            if (gnt_q) rdata1_d = m_rdata;
            else       rdata0_d = m_rdata;
          end
          state_d = DONE;
        end
      end
      DONE: begin
        prio_d  = ~gnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q  <= IDLE;
      gnt_q    <= 1'b0;
      prio_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
`ifdef APB_ARB_ADDR_CHECK_EN
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      prio_q   <= prio_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      write_q  <= write_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
`ifdef APB_ARB_ADDR_CHECK_EN
      err0_q   <= err0_d;
      err1_q   <= err1_d;
`endif
    end
  end

  assign transfer = (state_q == ISSUE);
  assign done0    = (state_q == DONE) & ~gnt_q;
  assign done1    = (state_q == DONE) &  gnt_q;
  assign m_addr   = addr_q;
  assign m_wdata  = wdata_q;
  assign m_write  = write_q;
  assign rdata0   = rdata0_q;
  assign rdata1   = rdata1_q;

endmodule
`default_nettype wire
